// File: rtl/clock_pkg.sv
// Purpose: shared speed encodings, FSM states and ce slot definitions for the CPU clock scheduler.
// Latency: functions only. They are evaluated combinationally by whichever module calls them.
// Backpressure: none; this package holds declarations only.
package clock_pkg;

    // Requested and applied CPU speed. The reserved code is folded onto 3.5 MHz on entry.
    typedef enum logic [1:0] {
        SPD_3M5  = 2'b00,
        SPD_7M   = 2'b01,
        SPD_14M  = 2'b10,
        SPD_RSVD = 2'b11
    } speed_t;

    // RUN: CPU enables follow the slot pattern. HOLD: CPU clock frozen by contention.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } sched_state_t;

    // Default for the maximum number of consecutive suppressed ce_p slots.
    localparam int HOLD_MAX_DEFAULT = 7;

    // The phase counter spans one 3.5 MHz CPU period of the 28 MHz master clock.
    localparam int                PH_W    = 3;
    localparam logic [PH_W-1:0]   PH_LAST = 3'd7;

    // Slot flags for a single phase.
    typedef struct packed {
        logic p;    // CPU rising-edge slot
        logic n;    // CPU falling-edge slot
        logic ula;  // 7 MHz pixel slot
    } ce_slots_t;

    // Map a raw speed request onto a supported speed. The reserved code runs at 3.5 MHz.
    function automatic speed_t speed_sanitize(input logic [1:0] raw);
        speed_t result;
        case (raw)
            2'b01:   result = SPD_7M;
            2'b10:   result = SPD_14M;
            default: result = SPD_3M5;
        endcase
        return result;
    endfunction

    // ce_p slots: all of them fall on odd phases and phase 7 belongs to every speed.
    // Because speed only switches at the 7 -> 0 boundary, two rising edges can never
    // end up closer than 2 cycles apart.
    function automatic logic slot_p(input logic [PH_W-1:0] ph, input speed_t spd);
        logic result;
        case (spd)
            SPD_7M:  result = (ph[1:0] == 2'b11);
            SPD_14M: result = ph[0];
            default: result = (ph == 3'd7);
        endcase
        return result;
    endfunction

    // ce_n slots sit halfway between the ce_p slots of the same speed.
    function automatic logic slot_n(input logic [PH_W-1:0] ph, input speed_t spd);
        logic result;
        case (spd)
            SPD_7M:  result = (ph[1:0] == 2'b01);
            SPD_14M: result = ~ph[0];
            default: result = (ph == 3'd3);
        endcase
        return result;
    endfunction

    // The pixel enable does not depend on CPU speed.
    function automatic logic slot_ula(input logic [PH_W-1:0] ph);
        return (ph[1:0] == 2'b11);
    endfunction

endpackage

// File: rtl/ce_decode.sv
// Purpose: decode phase + applied speed into ce_p / ce_n / ce_ula slot flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none. The caller gates the flags with the hold state.
// Ports: ph    - phase that the flags refer to
//        speed - speed in force during that phase
//        slots - {p, n, ula} slot flags
module ce_decode
    import clock_pkg::*;
(
    input  logic [PH_W-1:0] ph,
    input  speed_t          speed,
    output ce_slots_t       slots
);

    always_comb begin
        slots     = '0;
        slots.p   = slot_p(ph, speed);
        slots.n   = slot_n(ph, speed);
        slots.ula = slot_ula(ph);
    end

endmodule

// File: rtl/cpu_clock_sched.sv
// Purpose: generate CPU/ULA clock enables from the 28 MHz master clock, with contention hold.
// Latency: every output is registered. Inputs sampled at an edge affect the outputs of the next cycle.
// Backpressure: contend&vfetch holds ce_p/ce_n for at most HOLD_MAX slots, then the clock is forced through.
// Ports: clock, reset (sync, active high); speed request; contend/vfetch contention inputs;
//        ce_p/ce_n CPU edge enables; ce_ula pixel enable; speed_cur applied speed; stalled flag.
module cpu_clock_sched
    import clock_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
)(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] speed,
    input  logic       contend,
    input  logic       vfetch,
    output logic       ce_p,
    output logic       ce_n,
    output logic       ce_ula,
    output logic [1:0] speed_cur,
    output logic       stalled
);

    localparam int              CNT_W     = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(HOLD_MAX);

    logic [PH_W-1:0]  ph;
    logic [PH_W-1:0]  ph_next;
    sched_state_t     state;
    sched_state_t     state_next;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_next;
    speed_t           pending;
    speed_t           cur_spd;
    speed_t           speed_applied;
    logic             speed_commit;
    logic             contended;
    logic             ce_p_next;
    logic             ce_n_next;
    ce_slots_t        slots;

    // Outputs are registered. The decode therefore looks one cycle ahead: it uses
    // the phase and the speed that will hold in the cycle where the pulse appears.
    assign ph_next = ph + 1'b1;

    // The speed switch happens at the edge that ends a phase-7 cycle spent in RUN.
    // If the CPU is held at phase 7, the switch waits for a later phase 7 in RUN,
    // so the slot pattern never changes while the CPU clock is frozen.
    assign speed_commit  = (ph == PH_LAST) && (state == ST_RUN);
    assign speed_applied = speed_commit ? pending : cur_spd;

    // Contention is sampled at the edge that ends the cycle before a ce_p slot.
    // That is exactly when slots.p (the look-ahead flag) is high.
    assign contended = contend & vfetch;

    assign speed_cur = cur_spd;

    ce_decode u_decode (
        .ph    (ph_next),
        .speed (speed_applied),
        .slots (slots)
    );

    // State register and hold counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_RUN;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
        end
    end

    // Next-state and next-enable logic. hold_cnt counts suppressed ce_p slots
    // in a row. When it reaches the limit, the next slot is released even if
    // contention is still present.
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        ce_p_next     = 1'b0;
        ce_n_next     = 1'b0;
        case (state)
            ST_RUN: begin
                ce_n_next = slots.n;
                if (slots.p) begin
                    if (contended && (hold_cnt != CNT_LIMIT)) begin
                        state_next    = ST_HOLD;
                        hold_cnt_next = hold_cnt + 1'b1;
                    end else begin
                        ce_p_next     = 1'b1;
                        hold_cnt_next = '0;
                    end
                end
            end
            ST_HOLD: begin
                // ce_n stays frozen along with ce_p while the CPU is held.
                if (slots.p) begin
                    if (contended && (hold_cnt != CNT_LIMIT)) begin
                        hold_cnt_next = hold_cnt + 1'b1;
                    end else begin
                        state_next    = ST_RUN;
                        ce_p_next     = 1'b1;
                        hold_cnt_next = '0;
                    end
                end
            end
            default: begin
                state_next    = ST_RUN;
                hold_cnt_next = '0;
            end
        endcase
    end

    // Phase, speed and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            ph      <= '0;
            pending <= SPD_3M5;
            cur_spd <= SPD_3M5;
            ce_p    <= 1'b0;
            ce_n    <= 1'b0;
            ce_ula  <= 1'b0;
            stalled <= 1'b0;
        end else begin
            ph      <= ph_next;
            pending <= speed_sanitize(speed);
            if (speed_commit) begin
                cur_spd <= pending;
            end
            ce_p    <= ce_p_next;
            ce_n    <= ce_n_next;
            ce_ula  <= slots.ula;
            // stalled covers the first suppressed slot through the cycle before
            // the releasing ce_p. That window matches the HOLD state one cycle ahead.
            stalled <= (state_next == ST_HOLD);
        end
    end

endmodule

// File: tb/tb_cpu_clock_sched.sv
// Purpose: directed self-checking bench for cpu_clock_sched.
// Latency: the outputs of each cycle are sampled at the falling edge inside that cycle.
// Backpressure: n/a. Every wait is a bounded loop of clock edges, and a watchdog guards the run.
module tb_cpu_clock_sched;

    localparam int MAXC = 80;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] speed = 2'b00;
    logic       contend = 1'b0;
    logic       vfetch = 1'b0;
    logic       ce_p;
    logic       ce_n;
    logic       ce_ula;
    logic [1:0] speed_cur;
    logic       stalled;

    int checks = 0;
    int failures = 0;

    // Expected and captured traces. The index is the cycle number within a run,
    // and cycle 0 is the first cycle after the reset edge.
    bit         ep [MAXC];
    bit         en [MAXC];
    bit         eu [MAXC];
    bit         es [MAXC];
    logic [1:0] esc[MAXC];
    bit         gp [MAXC];
    bit         gn [MAXC];
    bit         gu [MAXC];
    bit         gs [MAXC];
    logic [1:0] gsc[MAXC];

    always #5 clock = ~clock;

    cpu_clock_sched dut (
        .clock     (clock),
        .reset     (reset),
        .speed     (speed),
        .contend   (contend),
        .vfetch    (vfetch),
        .ce_p      (ce_p),
        .ce_n      (ce_n),
        .ce_ula    (ce_ula),
        .speed_cur (speed_cur),
        .stalled   (stalled)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < MAXC; i++) begin
            ep[i]  = 1'b0;
            en[i]  = 1'b0;
            eu[i]  = 1'b0;
            es[i]  = 1'b0;
            esc[i] = 2'b00;
        end
    endtask

    // Hold reset high across two rising edges. On return the bench is at the
    // falling edge of cycle 0, with reset still high; drive() releases it.
    task automatic do_reset(input string name);
        @(negedge clock);
        reset   = 1'b1;
        speed   = 2'b00;
        contend = 1'b0;
        vfetch  = 1'b0;
        repeat (2) @(negedge clock);
        check({name, " rst ce_p"},      32'(ce_p),      32'd0);
        check({name, " rst ce_n"},      32'(ce_n),      32'd0);
        check({name, " rst ce_ula"},    32'(ce_ula),    32'd0);
        check({name, " rst stalled"},   32'(stalled),   32'd0);
        check({name, " rst speed_cur"}, 32'(speed_cur), 32'd0);
    endtask

    // Inputs are changed at the falling edge of cycle c, so the DUT sees them at the edge ending cycle c.
    task automatic drive(input int scn, input int c);
        if (c == 0) reset = 1'b0;
        case (scn)
            1: if (c == 0) speed = 2'b00;
            2: begin
                if (c == 0) speed = 2'b00;
                if (c == 2) speed = 2'b10;
            end
            3: begin
                if (c == 0) speed = 2'b01;
                if (c == 4) begin contend = 1'b1; vfetch = 1'b1; end
                if (c == 12) vfetch = 1'b0;
            end
            4: if (c == 0) begin speed = 2'b00; contend = 1'b1; vfetch = 1'b1; end
            5: begin
                if (c == 0) speed = 2'b01;
                if (c == 8) begin contend = 1'b1; vfetch = 1'b1; end
                if (c == 20) reset = 1'b1;
                if (c == 21) begin
                    reset = 1'b0; speed = 2'b00; contend = 1'b0; vfetch = 1'b0;
                end
            end
            6: if (c == 0) speed = 2'b11;
            default: ;
        endcase
    endtask

    task automatic run(input int scn, input int n, input string name);
        do_reset(name);
        for (int c = 0; c < n; c++) begin
            gp[c]  = ce_p;
            gn[c]  = ce_n;
            gu[c]  = ce_ula;
            gs[c]  = stalled;
            gsc[c] = speed_cur;
            drive(scn, c);
            @(negedge clock);
        end
        for (int c = 0; c < n; c++) begin
            check($sformatf("%s ce_p c%0d", name, c),      32'(gp[c]),  32'(ep[c]));
            check($sformatf("%s ce_n c%0d", name, c),      32'(gn[c]),  32'(en[c]));
            check($sformatf("%s ce_ula c%0d", name, c),    32'(gu[c]),  32'(eu[c]));
            check($sformatf("%s stalled c%0d", name, c),   32'(gs[c]),  32'(es[c]));
            check($sformatf("%s speed_cur c%0d", name, c), 32'(gsc[c]), 32'(esc[c]));
            check($sformatf("%s p_n_excl c%0d", name, c),  32'(gp[c] & gn[c]), 32'd0);
        end
    endtask

    initial begin
        // 3.5 MHz, no contention.
        clear_exp();
        ep[7] = 1; ep[15] = 1; ep[23] = 1;
        en[3] = 1; en[11] = 1; en[19] = 1;
        eu[3] = 1; eu[7] = 1; eu[11] = 1; eu[15] = 1; eu[19] = 1; eu[23] = 1;
        run(1, 24, "s35");

        // 3.5 -> 14 MHz requested at cycle 2, applied from cycle 8.
        clear_exp();
        ep[7] = 1; ep[9] = 1; ep[11] = 1; ep[13] = 1; ep[15] = 1;
        en[3] = 1; en[8] = 1; en[10] = 1; en[12] = 1; en[14] = 1;
        eu[3] = 1; eu[7] = 1; eu[11] = 1; eu[15] = 1;
        for (int c = 8; c < 16; c++) esc[c] = 2'b10;
        run(2, 16, "s14chg");

        // 7 MHz request with contention from cycle 4, vfetch dropped at 12.
        // The phase-7 slot is held, so the switch to 7 MHz waits for cycle 15.
        clear_exp();
        ep[15] = 1; ep[19] = 1; ep[23] = 1;
        en[3] = 1; en[17] = 1; en[21] = 1;
        eu[3] = 1; eu[7] = 1; eu[11] = 1; eu[15] = 1; eu[19] = 1; eu[23] = 1;
        for (int c = 7; c <= 14; c++) es[c] = 1;
        for (int c = 16; c < 24; c++) esc[c] = 2'b01;
        run(3, 24, "hold7");

        // Continuous contention at 3.5 MHz. Slots 7..55 are suppressed,
        // 63 is forced through, and 71 is held again.
        clear_exp();
        ep[63] = 1;
        en[3] = 1; en[67] = 1;
        for (int c = 3; c < 73; c += 4) eu[c] = 1;
        for (int c = 7; c <= 62; c++) es[c] = 1;
        es[71] = 1; es[72] = 1;
        run(4, 73, "holdmax");

        // Reset during HOLD at cycle 20. Cycle 21 is the first cycle of the new run.
        clear_exp();
        ep[7] = 1; ep[28] = 1;
        en[3] = 1; en[9] = 1; en[24] = 1;
        eu[3] = 1; eu[7] = 1; eu[11] = 1; eu[15] = 1; eu[19] = 1; eu[24] = 1; eu[28] = 1;
        for (int c = 11; c <= 20; c++) es[c] = 1;
        for (int c = 8; c <= 20; c++) esc[c] = 2'b01;
        run(5, 32, "rsthold");

        // Reserved speed code behaves like 3.5 MHz.
        clear_exp();
        ep[7] = 1; ep[15] = 1; ep[23] = 1;
        en[3] = 1; en[11] = 1; en[19] = 1;
        eu[3] = 1; eu[7] = 1; eu[11] = 1; eu[15] = 1; eu[19] = 1; eu[23] = 1;
        run(6, 24, "rsvd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
